// File: rtl/div_pkg.sv
// Shared constants and FSM encoding for the sequential 32/16 divider.
package div_pkg;

  localparam int DIVIDEND_W = 32;
  localparam int DIVISOR_W  = 16;
  localparam int ITER_N     = 32;
  localparam int CNT_W      = 5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_CALC = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } div_state_e;

  // Conditional two's-complement negate used for magnitudes and final signs.
  function automatic logic [DIVIDEND_W-1:0] neg32_if(input logic neg,
                                                     input logic [DIVIDEND_W-1:0] v);
    neg32_if = neg ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [DIVISOR_W-1:0] neg16_if(input logic neg,
                                                    input logic [DIVISOR_W-1:0] v);
    neg16_if = neg ? (~v + 16'd1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, subtract
// the divisor when it fits, and report the resulting quotient bit.
module div_step
  import div_pkg::*;
(
  input  logic [DIVISOR_W:0]   rem_in,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   rem_out,
  output logic                 q_bit
);

  // One extra bit above the 17-bit remainder keeps the compare exact even
  // when the incoming remainder has its top bit set (divide-by-zero case).
  logic [DIVISOR_W+1:0] shifted;
  logic [DIVISOR_W+1:0] diff;

  // Compare-and-subtract for a single quotient bit.
  always_comb begin
    shifted = {rem_in, bit_in};
    diff    = shifted - {2'b00, divisor};
    q_bit   = (shifted >= {2'b00, divisor});
    rem_out = q_bit ? diff[DIVISOR_W:0] : shifted[DIVISOR_W:0];
  end

endmodule

// File: rtl/div32_16_seq.sv
// Sequential 32/16 truncating divider, one quotient bit per cycle.
//
// Handshake: operands transfer on a rising edge where in_valid && in_ready
// (in_ready is high only in IDLE); results transfer on a rising edge where
// out_valid && out_ready (out_valid is high only in DONE). Results hold
// stable while out_valid is high and out_ready is low.
module div32_16_seq
  import div_pkg::*;
#(
  parameter int SIGNED = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero,
  output logic [2:0]            dbg_state
);

  div_state_e            state_q,   state_d;
  logic [CNT_W-1:0]      cnt_q,     cnt_d;
  logic [DIVIDEND_W-1:0] op_a_q,    op_a_d;     // raw latched dividend
  logic [DIVISOR_W-1:0]  op_b_q,    op_b_d;     // raw latched divisor
  logic [DIVIDEND_W-1:0] dvd_q,     dvd_d;      // dividend magnitude, shifted out MSB first
  logic [DIVISOR_W-1:0]  dsr_q,     dsr_d;      // divisor magnitude
  logic                  q_neg_q,   q_neg_d;
  logic                  r_neg_q,   r_neg_d;
  logic [DIVISOR_W:0]    rem_q,     rem_d;      // partial remainder
  logic [DIVIDEND_W-1:0] quo_q,     quo_d;      // quotient magnitude, shifted in LSB
  logic                  in_ready_q,  in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic [DIVIDEND_W-1:0] quotient_q,  quotient_d;
  logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
  logic                  dbz_q,       dbz_d;

  logic                  a_neg;
  logic                  b_neg;
  logic [DIVISOR_W:0]    step_rem;
  logic                  step_q;

  div_step u_step (
    .rem_in  (rem_q),
    .bit_in  (dvd_q[DIVIDEND_W-1]),
    .divisor (dsr_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // Next-state and datapath update for every FSM state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    dvd_d       = dvd_q;
    dsr_d       = dsr_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    a_neg       = (SIGNED != 0) && op_a_q[DIVIDEND_W-1];
    b_neg       = (SIGNED != 0) && op_b_q[DIVISOR_W-1];

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_a_d     = dividend;
          op_b_d     = divisor;
          in_ready_d = 1'b0;
          state_d    = ST_PREP;
        end
      end
      ST_PREP: begin
        // Magnitudes of the most negative values still fit unsigned.
        dvd_d   = neg32_if(a_neg, op_a_q);
        dsr_d   = neg16_if(b_neg, op_b_q);
        q_neg_d = a_neg ^ b_neg;
        r_neg_d = a_neg;
        rem_d   = '0;
        quo_d   = '0;
        cnt_d   = '0;
        state_d = ST_CALC;
      end
      ST_CALC: begin
        dvd_d = {dvd_q[DIVIDEND_W-2:0], 1'b0};
        rem_d = step_rem;
        quo_d = {quo_q[DIVIDEND_W-2:0], step_q};
        if (cnt_q == CNT_W'(ITER_N - 1)) begin
          cnt_d   = '0;
          state_d = ST_FIX;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_FIX: begin
        if (dsr_q == '0) begin
          quotient_d  = '1;
          remainder_d = op_a_q[DIVISOR_W-1:0];
          dbz_d       = 1'b1;
        end else begin
          quotient_d  = neg32_if(q_neg_q, quo_q);
          remainder_d = neg16_if(r_neg_q, rem_q[DIVISOR_W-1:0]);
          dbz_d       = 1'b0;
        end
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State register with synchronous active-low reset clearing everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      rem_q       <= '0;
      quo_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      dvd_q       <= dvd_d;
      dsr_q       <= dsr_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_div32_16_seq.sv
// Bench for div32_16_seq: signed and unsigned instances, vector table,
// randomized operations against an arithmetic model, and handshake/reset corners.
module tb_div32_16_seq;
  import div_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        iv_s, ir_s, ov_s, or_s, dz_s;
  logic [31:0] a_s, q_s;
  logic [15:0] b_s, r_s;
  logic [2:0]  st_s;
  logic        iv_u, ir_u, ov_u, or_u, dz_u;
  logic [31:0] a_u, q_u;
  logic [15:0] b_u, r_u;
  logic [2:0]  st_u;

  div32_16_seq #(.SIGNED(1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_s), .in_ready(ir_s),
    .dividend(a_s), .divisor(b_s), .out_valid(ov_s), .out_ready(or_s),
    .quotient(q_s), .remainder(r_s), .div_by_zero(dz_s), .dbg_state(st_s)
  );

  div32_16_seq #(.SIGNED(0)) u_dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_u), .in_ready(ir_u),
    .dividend(a_u), .divisor(b_u), .out_valid(ov_u), .out_ready(or_u),
    .quotient(q_u), .remainder(r_u), .div_by_zero(dz_u), .dbg_state(st_u)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit          uns;
    logic [31:0] a;
    logic [15:0] b;
    logic [31:0] q;
    logic [15:0] r;
    bit          dz;
  } vec_t;

  vec_t tbl[13];

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic; SV division truncates toward zero
  // and the remainder follows the dividend's sign.
  function automatic void ref_div(input bit uns, input logic [31:0] a, input logic [15:0] b,
                                  output logic [31:0] q, output logic [15:0] r, output bit dz);
    longint x, y, qq, rr;
    if (b == 16'd0) begin
      q = 32'hFFFF_FFFF; r = a[15:0]; dz = 1'b1;
    end else begin
      if (uns) begin
        x = longint'({32'd0, a});
        y = longint'({48'd0, b});
      end else begin
        x = longint'($signed(a));
        y = longint'($signed(b));
      end
      qq = x / y;
      rr = x % y;
      q = qq[31:0]; r = rr[15:0]; dz = 1'b0;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_in(input bit uns, input logic v, input logic [31:0] a, input logic [15:0] b);
    if (uns) begin iv_u = v; a_u = a; b_u = b; end
    else     begin iv_s = v; a_s = a; b_s = b; end
  endtask

  task automatic drive_or(input bit uns, input logic v);
    if (uns) or_u = v; else or_s = v;
  endtask

  task automatic read_out(input bit uns, output logic ov, output logic ir, output logic [31:0] q,
                          output logic [15:0] r, output logic dz, output logic [2:0] st);
    if (uns) begin ov = ov_u; ir = ir_u; q = q_u; r = r_u; dz = dz_u; st = st_u; end
    else     begin ov = ov_s; ir = ir_s; q = q_s; r = r_s; dz = dz_s; st = st_s; end
  endtask

  // Present operands, count edges from acceptance to out_valid (bounded).
  task automatic start_and_wait(input bit uns, input logic [31:0] a, input logic [15:0] b,
                                input bit scramble);
    logic ov, ir, dz; logic [31:0] q; logic [15:0] r; logic [2:0] st;
    int lat;
    @(negedge clk);
    drive_in(uns, 1'b1, a, b);
    read_out(uns, ov, ir, q, r, dz, st);
    chk("in_ready before accept", {63'd0, ir}, 64'd1);
    @(posedge clk); #1;
    if (scramble) drive_in(uns, 1'b0, $urandom, 16'($urandom));
    else          drive_in(uns, 1'b0, a, b);
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      read_out(uns, ov, ir, q, r, dz, st);
      if (ov) begin lat = n; break; end
    end
    chk("latency", 64'(lat), 64'd34);
  endtask

  task automatic check_result(input bit uns, input string tag, input logic [31:0] eq,
                              input logic [15:0] er, input bit edz);
    logic ov, ir, dz; logic [31:0] q; logic [15:0] r; logic [2:0] st;
    read_out(uns, ov, ir, q, r, dz, st);
    chk({tag, " quotient"}, {32'd0, q}, {32'd0, eq});
    chk({tag, " remainder"}, {48'd0, r}, {48'd0, er});
    chk({tag, " div_by_zero"}, {63'd0, dz}, {63'd0, edz});
    chk({tag, " in_ready in DONE"}, {63'd0, ir}, 64'd0);
  endtask

  task automatic release_out(input bit uns);
    logic ov, ir, dz; logic [31:0] q; logic [15:0] r; logic [2:0] st;
    @(negedge clk);
    drive_or(uns, 1'b1);
    @(posedge clk); #1;
    drive_or(uns, 1'b0);
    read_out(uns, ov, ir, q, r, dz, st);
    chk("in_ready after handshake", {63'd0, ir}, 64'd1);
    chk("out_valid after handshake", {63'd0, ov}, 64'd0);
  endtask

  task automatic do_op(input bit uns, input string tag, input logic [31:0] a, input logic [15:0] b,
                       input bit scramble);
    logic [31:0] eq; logic [15:0] er; bit edz;
    ref_div(uns, a, b, eq, er, edz);
    start_and_wait(uns, a, b, scramble);
    check_result(uns, tag, eq, er, edz);
    release_out(uns);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic ov, ir, dz; logic [31:0] q; logic [15:0] r; logic [2:0] st;
    logic [31:0] eq; logic [15:0] er; bit edz;
    bit seen;

    tbl[0]  = '{0, 32'd100,        16'd7,      32'd14,         16'd2,      0};
    tbl[1]  = '{0, 32'hFFFFFF9C,   16'd7,      32'hFFFFFFF2,   16'hFFFE,   0};
    tbl[2]  = '{0, 32'h80000000,   16'hFFFF,   32'h80000000,   16'h0000,   0};
    tbl[3]  = '{1, 32'hFFFFFFFF,   16'hFFFF,   32'h00010001,   16'h0000,   0};
    tbl[4]  = '{0, 32'd1234,       16'd0,      32'hFFFFFFFF,   16'h04D2,   1};
    tbl[5]  = '{1, 32'd1234,       16'd0,      32'hFFFFFFFF,   16'h04D2,   1};
    tbl[6]  = '{0, 32'd100,        16'hFFF9,   32'hFFFFFFF2,   16'd2,      0};
    tbl[7]  = '{0, 32'hFFFFFFF9,   16'd2,      32'hFFFFFFFD,   16'hFFFF,   0};
    tbl[8]  = '{0, 32'd7,          16'd100,    32'd0,          16'd7,      0};
    tbl[9]  = '{1, 32'hFFFFFFFF,   16'd1,      32'hFFFFFFFF,   16'd0,      0};
    tbl[10] = '{0, 32'h80000000,   16'h8000,   32'h00010000,   16'd0,      0};
    tbl[11] = '{1, 32'h80000000,   16'h8000,   32'h00010000,   16'd0,      0};
    tbl[12] = '{0, 32'hFFFFFB2E,   16'd0,      32'hFFFFFFFF,   16'hFB2E,   1};

    rst_n = 1'b0;
    iv_s = 0; a_s = 0; b_s = 0; or_s = 0;
    iv_u = 0; a_u = 0; b_u = 0; or_u = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      read_out(u[0], ov, ir, q, r, dz, st);
      chk("reset in_ready", {63'd0, ir}, 64'd1);
      chk("reset out_valid", {63'd0, ov}, 64'd0);
      chk("reset quotient", {32'd0, q}, 64'd0);
      chk("reset remainder", {48'd0, r}, 64'd0);
      chk("reset div_by_zero", {63'd0, dz}, 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table.
    for (int i = 0; i < 13; i++) begin
      start_and_wait(tbl[i].uns, tbl[i].a, tbl[i].b, 1'b0);
      check_result(tbl[i].uns, $sformatf("vec%0d", i), tbl[i].q, tbl[i].r, tbl[i].dz);
      release_out(tbl[i].uns);
    end

    // Consumer stalls 10 cycles in DONE while a stray in_valid pulse arrives.
    ref_div(0, 32'h12345678, 16'h0123, eq, er, edz);
    start_and_wait(0, 32'h12345678, 16'h0123, 1'b1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      drive_in(0, (c == 3 || c == 4), 32'd999, 16'd3);
      @(posedge clk); #1;
      read_out(0, ov, ir, q, r, dz, st);
      chk("stall out_valid", {63'd0, ov}, 64'd1);
      chk("stall in_ready", {63'd0, ir}, 64'd0);
      chk("stall quotient", {32'd0, q}, {32'd0, eq});
      chk("stall remainder", {48'd0, r}, {48'd0, er});
    end
    drive_in(0, 1'b0, 32'd0, 16'd0);
    release_out(0);
    do_op(0, "after stall", 32'd100, 16'd7, 1'b0);

    // Reset at CALC iteration 10 aborts the operation.
    @(negedge clk);
    drive_in(0, 1'b1, 32'hDEADBEEF, 16'h0037);
    @(posedge clk); #1;                     // accepting edge
    drive_in(0, 1'b0, 32'd0, 16'd0);
    repeat (11) @(posedge clk);             // PREP->CALC, then counter reaches 10
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    read_out(0, ov, ir, q, r, dz, st);
    chk("abort state", {61'd0, st}, {61'd0, ST_IDLE});
    chk("abort in_ready", {63'd0, ir}, 64'd1);
    chk("abort out_valid", {63'd0, ov}, 64'd0);
    chk("abort quotient", {32'd0, q}, 64'd0);
    chk("abort remainder", {48'd0, r}, 64'd0);
    chk("abort div_by_zero", {63'd0, dz}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (ov_s) seen = 1'b1;
    end
    chk("no result after abort", {63'd0, seen}, 64'd0);
    do_op(0, "after abort", 32'd100, 16'd7, 1'b0);

    // Randomized operations with operands scrambled after acceptance.
    for (int i = 0; i < 60; i++) begin
      bit          uns;
      logic [31:0] a;
      logic [15:0] b;
      uns = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0:       b = 16'd0;
        1:       b = 16'hFFFF;
        2:       b = 16'h8000;
        3:       b = 16'd1;
        default: b = 16'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0:       a = 32'h80000000;
        1:       a = 32'hFFFFFFFF;
        2:       a = 32'($urandom_range(0, 300));
        default: a = $urandom;
      endcase
      do_op(uns, $sformatf("rand%0d", i), a, b, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/div32_16_seq.md
DIV32_16_SEQ -- requirements
Module: div32_16_seq

Interface
REQ-001 SHALL have parameter SIGNED, default 1: 1 = two's-complement operands and results; 0 = unsigned.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operands valid.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port dividend  input  32  dividend.
REQ-007 SHALL have port divisor  input  16  divisor.
REQ-008 SHALL have port out_valid  output  1  results valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts results.
REQ-010 SHALL have port quotient  output  32  quotient.
REQ-011 SHALL have port remainder  output  16  remainder.
REQ-012 SHALL have port div_by_zero  output  1  divisor was zero for the current result.

Function
REQ-013 SHALL implement FSM states IDLE, PREP, CALC, FIX, DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE; operands latched on the edge where in_valid&&in_ready, then IDLE->PREP.
REQ-015 PREP SHALL register operand magnitudes and result signs (SIGNED=1) or raw operands (SIGNED=0), then go to CALC with the iteration counter at 0.
REQ-016 CALC SHALL resolve one quotient bit per cycle, MSB first, via a 17-bit partial remainder shift/subtract; exactly 32 cycles, then FIX.
REQ-017 FIX SHALL apply signs and register outputs, then go to DONE.
REQ-018 out_valid SHALL assert exactly 34 rising edges after the accepting edge, for every operand value including divide-by-zero.
REQ-019 Results SHALL use truncating division: quotient rounds toward zero; remainder takes the dividend's sign; dividend == quotient*divisor + remainder.
REQ-020 SIGNED=1, dividend 0x80000000 / divisor 0xFFFF SHALL give quotient 0x80000000 (wraps), remainder 0, div_by_zero=0.
REQ-021 divisor==0 SHALL give quotient 0xFFFFFFFF, remainder dividend[15:0], div_by_zero=1.
REQ-022 In DONE, out_valid=1; quotient, remainder and div_by_zero SHALL hold stable until out_valid&&out_ready.
REQ-023 On the out_valid&&out_ready edge the FSM SHALL go DONE->IDLE; in_ready rises the following cycle. The block does not accept back-to-back operations.
REQ-024 in_valid SHALL be ignored outside IDLE, and operand changes after the accepting edge SHALL have no effect.
REQ-025 out_ready SHALL be ignored outside DONE.

Reset
REQ-026 With rst_n=0 at a rising edge, the state SHALL become IDLE and the counter 0.
REQ-027 Reset values SHALL be: in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, all internal datapath registers 0.
REQ-028 Reset in any state, including mid-CALC or DONE with out_ready low, SHALL abort the operation with no partial result emitted.

Structure
REQ-029 A shared package div_pkg SHALL hold the FSM state encoding, DIVIDEND_W=32, DIVISOR_W=16, and the iteration count 32.
REQ-030 One combinational sub-module div_step SHALL implement a single iteration: 17-bit partial remainder and next dividend bit in, updated partial remainder and quotient bit out.
REQ-031 The top level SHALL contain the FSM, counter, operand/sign registers and output registers only.

Verification
REQ-032 SIGNED=1: 100/7 -> quotient 14, remainder 2, out_valid exactly 34 edges after acceptance.
REQ-033 SIGNED=1: -100/7 -> quotient 0xFFFFFFF2, remainder 0xFFFE; and 0x80000000/0xFFFF -> quotient 0x80000000, remainder 0.
REQ-034 SIGNED=0: 0xFFFFFFFF/0xFFFF -> quotient 0x00010001, remainder 0, div_by_zero=0.
REQ-035 1234/0 -> quotient 0xFFFFFFFF, remainder 0x04D2, div_by_zero=1, still 34-edge latency.
REQ-036 out_ready low 10 cycles in DONE, with in_valid pulsed meanwhile -> outputs stable, in_ready=0, pulse ignored; after out_ready=1, in_ready=1 next cycle and the next operation is accepted normally.
REQ-037 rst_n=0 at CALC iteration 10 -> next cycle state IDLE, in_ready=1, out_valid=0, outputs 0; a subsequent 100/7 completes correctly.
